// File: rtl/sb_config_loader.sv
// Serial bitstream loader for the switch-box array; shadow frame, atomic commit.
// Define SB_CFG_PARITY_EN for a 13th even-parity bit per word and the ERROR path.
module sb_config_loader #(
    parameter int NUM_SB = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                cfg_bit,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    output logic [6*NUM_SB-1:0] dir_out,
    output logic [6*NUM_SB-1:0] en_out,
    output logic                busy,
    output logic                done,
    output logic                err
);

    localparam int SBW = (NUM_SB > 1) ? $clog2(NUM_SB) : 1;
    localparam int FW  = 12 * NUM_SB;
    localparam logic [SBW-1:0] LAST_SB = SBW'(NUM_SB - 1);
`ifdef SB_CFG_PARITY_EN
    localparam logic [3:0] LAST_BIT = 4'd12;
`else
    localparam logic [3:0] LAST_BIT = 4'd11;
`endif

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        COMMIT,
        ERROR
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      bit_cnt;
    logic [SBW-1:0]  sb_cnt;
    logic [FW-1:0]   shadow;
    logic [FW-1:0]   out_q;
    logic            done_q;
    logic            accept;
    logic            load_start;
    logic            word_end;
    logic            par_bad;

    assign accept     = (state_q == SHIFT) && cfg_valid;
    assign load_start = start && (state_q == IDLE || state_q == ERROR);
    assign word_end   = (bit_cnt == LAST_BIT);

`ifdef SB_CFG_PARITY_EN
    logic par;
    assign par_bad = accept && word_end && (par ^ cfg_bit);
    assign err     = (state_q == ERROR);
`else
    assign par_bad = 1'b0;
    assign err     = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:   if (start) state_d = SHIFT;
            SHIFT: begin
                if (par_bad)
                    state_d = ERROR;
                else if (accept && word_end && sb_cnt == LAST_SB)
                    state_d = COMMIT;
            end
            COMMIT: state_d = IDLE;
            ERROR:  if (start) state_d = SHIFT;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt <= '0;
            sb_cnt  <= '0;
            shadow  <= '0;
            out_q   <= '0;
            done_q  <= 1'b0;
`ifdef SB_CFG_PARITY_EN
            par     <= 1'b0;
`endif
        end else begin
            done_q <= (state_q == COMMIT);
            if (load_start) begin
                bit_cnt <= '0;
                sb_cnt  <= '0;
`ifdef SB_CFG_PARITY_EN
                par     <= 1'b0;
`endif
            end else if (accept) begin
                if (word_end) begin
                    bit_cnt <= '0;
                    sb_cnt  <= sb_cnt + 1'b1;
                end else begin
                    bit_cnt <= bit_cnt + 4'd1;
                end
`ifdef SB_CFG_PARITY_EN
                // parity bit closes the word and is not stored
                if (word_end) begin
                    par <= 1'b0;
                end else begin
                    par    <= par ^ cfg_bit;
                    shadow <= {cfg_bit, shadow[FW-1:1]};
                end
`else
                shadow <= {cfg_bit, shadow[FW-1:1]};
`endif
            end
            if (state_q == COMMIT) out_q <= shadow;
        end
    end

    // out_q holds {dir, en} per switch box, box 0 in the low word
    for (genvar k = 0; k < NUM_SB; k++) begin : g_sb
        assign en_out[6*k +: 6]  = out_q[12*k +: 6];
        assign dir_out[6*k +: 6] = out_q[12*k+6 +: 6];
    end

    assign cfg_ready = (state_q == SHIFT);
    assign busy      = (state_q == SHIFT) || (state_q == COMMIT);
    assign done      = done_q;

endmodule

// File: tb/tb_sb_config_loader.sv
// Directed bench for sb_config_loader, NUM_SB=2.
// Parity scenarios run when SB_CFG_PARITY_EN is defined.
module tb_sb_config_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        cfg_bit = 1'b0;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [11:0] dir_out;
    logic [11:0] en_out;
    logic        busy;
    logic        done;
    logic        err;

    int checks = 0;
    int errors = 0;

`ifdef SB_CFG_PARITY_EN
    localparam int FL = 26;
`else
    localparam int FL = 24;
`endif

    sb_config_loader #(.NUM_SB(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .cfg_bit   (cfg_bit),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .dir_out   (dir_out),
        .en_out    (en_out),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [25:0] mk(input logic [11:0] w0,
                                       input logic [11:0] w1,
                                       input bit bad);
`ifdef SB_CFG_PARITY_EN
        return {(^w1) ^ bad, w1, ^w0, w0};
`else
        return {2'b00, w1, w0};
`endif
    endfunction

    task automatic begin_load();
        start = 1'b1;
        step();
        start = 1'b0;
        check("start_ready", 32'(cfg_ready), 32'd1);
        check("start_busy", 32'(busy), 32'd1);
    endtask

    task automatic send(input logic [25:0] bits, input int n,
                        input bit toggle, input int start_at);
        for (int i = 0; i < n; i++) begin
            if (toggle) begin
                cfg_valid = 1'b0;
                cfg_bit   = ~bits[i];
                step();
                check("stall_ready", 32'(cfg_ready), 32'd1);
            end
            cfg_valid = 1'b1;
            cfg_bit   = bits[i];
            start     = (i == start_at);
            step();
            start     = 1'b0;
        end
        cfg_valid = 1'b0;
    endtask

    task automatic finish_commit(input string tag, input logic [11:0] old_en,
                                 input logic [11:0] old_dir,
                                 input logic [11:0] new_en,
                                 input logic [11:0] new_dir);
        check({tag, "_pre_en"}, 32'(en_out), 32'(old_en));
        check({tag, "_pre_dir"}, 32'(dir_out), 32'(old_dir));
        check({tag, "_commit_busy"}, 32'(busy), 32'd1);
        check({tag, "_commit_ready"}, 32'(cfg_ready), 32'd0);
        check({tag, "_pre_done"}, 32'(done), 32'd0);
        step();
        check({tag, "_en"}, 32'(en_out), 32'(new_en));
        check({tag, "_dir"}, 32'(dir_out), 32'(new_dir));
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_busy_after"}, 32'(busy), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
        step();
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        check("rst_dir", 32'(dir_out), 32'h0);
        check("rst_en", 32'(en_out), 32'h0);
        check("rst_ready", 32'(cfg_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);

        // valid while idle must not consume bits
        cfg_valid = 1'b1;
        cfg_bit   = 1'b1;
        step();
        step();
        cfg_valid = 1'b0;
        check("idle_ready", 32'(cfg_ready), 32'd0);

        begin_load();
        send(mk(12'h03F, 12'hA15, 1'b0), FL, 1'b0, -1);
        finish_commit("full", 12'h000, 12'h000, 12'h57F, 12'hA00);

        rst = 1'b1;
        step();
        rst = 1'b0;
        begin_load();
        send(mk(12'h03F, 12'hA15, 1'b0), FL, 1'b1, -1);
        finish_commit("toggle", 12'h000, 12'h000, 12'h57F, 12'hA00);

        begin_load();
        send(mk(12'h5A3, 12'h0C6, 1'b0), 10, 1'b0, -1);
        check("mid_en_hold", 32'(en_out), 32'h57F);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_en", 32'(en_out), 32'h0);
        check("midrst_dir", 32'(dir_out), 32'h0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_ready", 32'(cfg_ready), 32'd0);
        begin_load();
        send(mk(12'h03F, 12'hA15, 1'b0), FL, 1'b0, -1);
        finish_commit("fresh", 12'h000, 12'h000, 12'h57F, 12'hA00);

        begin_load();
        send(mk(12'h5A3, 12'h0C6, 1'b0), FL, 1'b0, 5);
        finish_commit("startmid", 12'h57F, 12'hA00, 12'h1A3, 12'h0D6);

`ifdef SB_CFG_PARITY_EN
        begin_load();
        send(mk(12'h03F, 12'hA15, 1'b1), FL, 1'b0, -1);
        check("par_err", 32'(err), 32'd1);
        check("par_ready", 32'(cfg_ready), 32'd0);
        check("par_busy", 32'(busy), 32'd0);
        check("par_done", 32'(done), 32'd0);
        step();
        check("par_err_sticky", 32'(err), 32'd1);
        check("par_nodone", 32'(done), 32'd0);
        check("par_en_hold", 32'(en_out), 32'h1A3);
        check("par_dir_hold", 32'(dir_out), 32'h0D6);
        begin_load();
        check("par_err_clr", 32'(err), 32'd0);
        send(mk(12'h03F, 12'hA15, 1'b0), FL, 1'b0, -1);
        finish_commit("par_ok", 12'h1A3, 12'h0D6, 12'h57F, 12'hA00);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
